face_detect_div_24s_8s_16_seq: RTL and testbench

//  Iterative signed divider: 24-bit signed dividend / 8-bit signed divisor -> 16-bit signed quotient + 8-bit remainder.

---
 rtl/face_detect_div_pkg.sv | 30 +++
 rtl/face_detect_div_24s_8s_16_seq_if.sv | 27 ++
 rtl/face_detect_div_step.sv | 21 ++
 rtl/face_detect_div_24s_8s_16_seq.sv | 141 ++++++++++++++
 tb/tb_face_detect_div_24s_8s_16_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/face_detect_div_pkg.sv
// Shared widths, FSM encoding and saturation limits for the face_detect
// 24s / 8s -> 16s sequential divider.
package face_detect_div_pkg;

    localparam int DIVIDEND_WIDTH = 24;
    localparam int DIVISOR_WIDTH  = 8;
    localparam int QUOTIENT_WIDTH = 16;
    localparam int CNT_WIDTH      = 5;

    localparam logic [CNT_WIDTH-1:0]      LAST_STEP = 5'd23;
    localparam logic [QUOTIENT_WIDTH-1:0] QMAX      = 16'h7FFF;
    localparam logic [QUOTIENT_WIDTH-1:0] QMIN      = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Unsigned magnitude without a sign bit, so -8388608 maps to 24'h800000.
    function automatic logic [DIVIDEND_WIDTH-1:0] mag_dividend(input logic [DIVIDEND_WIDTH-1:0] v);
        return v[DIVIDEND_WIDTH-1] ? (~v + 24'd1) : v;
    endfunction

    function automatic logic [DIVISOR_WIDTH-1:0] mag_divisor(input logic [DIVISOR_WIDTH-1:0] v);
        return v[DIVISOR_WIDTH-1] ? (~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/face_detect_div_24s_8s_16_seq_if.sv
// Operand/result bundle of the sequential divider. Both sides use valid/ready:
// a transfer happens on a ce-qualified rising edge where valid and ready are both high.
interface face_detect_div_24s_8s_16_seq_if;
    import face_detect_div_pkg::*;

    logic                      din_vld;
    logic                      din_rdy;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      dout_vld;
    logic                      dout_rdy;
    logic [QUOTIENT_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      ovf;
    logic                      div_zero;

    modport slave (
        input  din_vld, dividend, divisor, dout_rdy,
        output din_rdy, dout_vld, quotient, remainder, ovf, div_zero
    );

    modport master (
        output din_vld, dividend, divisor, dout_rdy,
        input  din_rdy, dout_vld, quotient, remainder, ovf, div_zero
    );

endinterface

// File: rtl/face_detect_div_step.sv
// One restoring radix-2 step: shift the next dividend bit into the partial
// remainder and keep the trial subtraction when it does not go negative.
module face_detect_div_step
    import face_detect_div_pkg::*;
(
    input  logic [DIVISOR_WIDTH:0]   i_prem,
    input  logic [DIVISOR_WIDTH-1:0] i_dsr,
    input  logic                     i_bit,
    output logic [DIVISOR_WIDTH:0]   o_prem,
    output logic                     o_qbit
);

    logic [DIVISOR_WIDTH+1:0] w_sh;
    logic [DIVISOR_WIDTH+2:0] w_diff;

    assign w_sh   = {i_prem, i_bit};
    assign w_diff = {1'b0, w_sh} - {3'b000, i_dsr};
    assign o_qbit = ~w_diff[DIVISOR_WIDTH+2];
    assign o_prem = o_qbit ? w_diff[DIVISOR_WIDTH:0] : w_sh[DIVISOR_WIDTH:0];

endmodule

// File: rtl/face_detect_div_24s_8s_16_seq.sv
// Sequential signed divider, truncating toward zero with a saturated 16-bit
// quotient; one quotient bit per ce-qualified cycle.
module face_detect_div_24s_8s_16_seq
    import face_detect_div_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   ce,
    face_detect_div_24s_8s_16_seq_if.slave div_if,
    output state_t o_dbg_state
);

    localparam logic signed [DIVIDEND_WIDTH:0] Q_HI = 25'sd32767;
    localparam logic signed [DIVIDEND_WIDTH:0] Q_LO = -25'sd32768;

    state_t                    r_state;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [DIVIDEND_WIDTH-1:0] r_dvd;
    logic [DIVISOR_WIDTH-1:0]  r_dsr;
    logic [DIVISOR_WIDTH:0]    r_prem;
    logic [DIVISOR_WIDTH-1:0]  r_dvd_lo;
    logic                      r_dvd_neg;
    logic                      r_dsr_neg;
    logic                      r_dz;
    logic                      r_din_rdy;
    logic                      r_dout_vld;
    logic [QUOTIENT_WIDTH-1:0] r_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_remainder;
    logic                      r_ovf;
    logic                      r_div_zero;

    logic [DIVISOR_WIDTH:0]           w_prem_nxt;
    logic                             w_qbit;
    logic                             w_q_neg;
    logic [DIVIDEND_WIDTH:0]          w_q_mag;
    logic signed [DIVIDEND_WIDTH:0]   w_q_s;
    logic [DIVISOR_WIDTH-1:0]         w_rem;

    face_detect_div_step u_step (
        .i_prem (r_prem),
        .i_dsr  (r_dsr),
        .i_bit  (r_dvd[DIVIDEND_WIDTH-1]),
        .o_prem (w_prem_nxt),
        .o_qbit (w_qbit)
    );

    // r_dvd doubles as the quotient: dividend bits leave at the top while
    // quotient bits enter at the bottom, so after 24 steps it holds |q|.
    assign w_q_neg = r_dvd_neg ^ r_dsr_neg;
    assign w_q_mag = {1'b0, r_dvd};
    assign w_q_s   = w_q_neg ? $signed(25'd0 - w_q_mag) : $signed(w_q_mag);
    assign w_rem   = r_dvd_neg ? (8'd0 - r_prem[DIVISOR_WIDTH-1:0]) : r_prem[DIVISOR_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_prem      <= '0;
            r_dvd_lo    <= '0;
            r_dvd_neg   <= 1'b0;
            r_dsr_neg   <= 1'b0;
            r_dz        <= 1'b0;
            r_din_rdy   <= 1'b1;
            r_dout_vld  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_div_zero  <= 1'b0;
        end else if (ce) begin
            case (r_state)
                IDLE: begin
                    if (div_if.din_vld) begin
                        r_dvd     <= mag_dividend(div_if.dividend);
                        r_dsr     <= mag_divisor(div_if.divisor);
                        r_dvd_neg <= div_if.dividend[DIVIDEND_WIDTH-1];
                        r_dsr_neg <= div_if.divisor[DIVISOR_WIDTH-1];
                        r_dvd_lo  <= div_if.dividend[DIVISOR_WIDTH-1:0];
                        r_dz      <= (div_if.divisor == '0);
                        r_prem    <= '0;
                        r_cnt     <= '0;
                        r_din_rdy <= 1'b0;
                        r_state   <= (div_if.divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_prem <= w_prem_nxt;
                    r_dvd  <= {r_dvd[DIVIDEND_WIDTH-2:0], w_qbit};
                    if (r_cnt == LAST_STEP) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (r_dz) begin
                        r_quotient  <= r_dvd_neg ? QMIN : QMAX;
                        r_remainder <= r_dvd_lo;
                        r_ovf       <= 1'b0;
                        r_div_zero  <= 1'b1;
                    end else begin
                        if (w_q_s > Q_HI) begin
                            r_quotient <= QMAX;
                            r_ovf      <= 1'b1;
                        end else if (w_q_s < Q_LO) begin
                            r_quotient <= QMIN;
                            r_ovf      <= 1'b1;
                        end else begin
                            r_quotient <= w_q_s[QUOTIENT_WIDTH-1:0];
                            r_ovf      <= 1'b0;
                        end
                        r_remainder <= w_rem;
                        r_div_zero  <= 1'b0;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    // First DONE cycle raises dout_vld; consumption only counts once it is visible.
                    if (!r_dout_vld) begin
                        r_dout_vld <= 1'b1;
                    end else if (div_if.dout_rdy) begin
                        r_dout_vld <= 1'b0;
                        r_din_rdy  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign div_if.din_rdy   = r_din_rdy;
    assign div_if.dout_vld  = r_dout_vld;
    assign div_if.quotient  = r_quotient;
    assign div_if.remainder = r_remainder;
    assign div_if.ovf       = r_ovf;
    assign div_if.div_zero  = r_div_zero;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_face_detect_div_24s_8s_16_seq.sv
// Directed bench for the sequential signed divider: latency, signs,
// saturation, divide-by-zero, backpressure, ce stall, async reset, model sweep.
module tb_face_detect_div_24s_8s_16_seq;
    import face_detect_div_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   ce;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;

    face_detect_div_24s_8s_16_seq_if dif ();

    face_detect_div_24s_8s_16_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .div_if      (dif.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [23:0] dvd, input logic [7:0] dsr);
        int guard = 0;
        while (dif.din_rdy !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        check("din_rdy_before_accept", 32'(dif.din_rdy), 32'(1));
        dif.dividend = dvd;
        dif.divisor  = dsr;
        dif.din_vld  = 1'b1;
        tick();
        dif.din_vld  = 1'b0;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (dif.dout_vld === 1'b1) break;
        end
        check("dout_vld_seen", 32'(dif.dout_vld), 32'(1));
    endtask

    task automatic check_result(input string tag, input logic [15:0] q, input logic [7:0] r,
                                input logic ovf, input logic dz);
        check({tag, "_q"},   32'(dif.quotient),  32'(q));
        check({tag, "_r"},   32'(dif.remainder), 32'(r));
        check({tag, "_ovf"}, 32'(dif.ovf),       32'(ovf));
        check({tag, "_dz"},  32'(dif.div_zero),  32'(dz));
    endtask

    task automatic consume(input string tag);
        dif.dout_rdy = 1'b1;
        tick();
        dif.dout_rdy = 1'b0;
        check({tag, "_vld_drop"}, 32'(dif.dout_vld),  32'(0));
        check({tag, "_rdy_back"}, 32'(dif.din_rdy),   32'(1));
        check({tag, "_idle"},     32'(dbg_state),     32'(IDLE));
    endtask

    task automatic run_op(input string tag, input logic [23:0] dvd, input logic [7:0] dsr,
                          input logic [15:0] q, input logic [7:0] r, input logic ovf,
                          input logic dz, input int lat);
        int n;
        start_op(dvd, dsr);
        wait_vld(n);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check_result(tag, q, r, ovf, dz);
        consume(tag);
    endtask

    // Reference: C integer division truncating toward zero, then saturation.
    function automatic void model(input logic [23:0] dvd, input logic [7:0] dsr,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic ovf, output logic dz);
        int a, b, qi, ri;
        a = $signed(dvd);
        b = $signed(dsr);
        if (b == 0) begin
            dz = 1'b1; ovf = 1'b0;
            q = (a < 0) ? 16'h8000 : 16'h7FFF;
            r = dvd[7:0];
        end else begin
            qi = a / b;
            ri = a % b;
            dz = 1'b0;
            if (qi > 32767) begin
                q = 16'h7FFF; ovf = 1'b1;
            end else if (qi < -32768) begin
                q = 16'h8000; ovf = 1'b1;
            end else begin
                q = qi[15:0]; ovf = 1'b0;
            end
            r = ri[7:0];
        end
    endfunction

    initial begin
        int          n;
        logic [15:0] mq;
        logic [7:0]  mr;
        logic        movf, mdz;
        logic [23:0] rdvd;
        logic [7:0]  rdsr;
        logic [15:0] x16;

        reset_n      = 1'b0;
        ce           = 1'b1;
        dif.din_vld  = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        dif.dout_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_rdy",  32'(dif.din_rdy),   32'(1));
        check("rst_dout_vld", 32'(dif.dout_vld),  32'(0));
        check("rst_q",        32'(dif.quotient),  32'(0));
        check("rst_r",        32'(dif.remainder), 32'(0));
        check("rst_ovf",      32'(dif.ovf),       32'(0));
        check("rst_dz",       32'(dif.div_zero),  32'(0));
        check("rst_state",    32'(dbg_state),     32'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Sign combinations, 1000 / 7 = 142 r 6
        run_op("pp", 24'h0003E8, 8'h07, 16'h008E, 8'h06, 1'b0, 1'b0, 26);
        run_op("np", 24'hFFFC18, 8'h07, 16'hFF72, 8'hFA, 1'b0, 1'b0, 26);
        run_op("pn", 24'h0003E8, 8'hF9, 16'hFF72, 8'h06, 1'b0, 1'b0, 26);
        run_op("nn", 24'hFFFC18, 8'hF9, 16'h008E, 8'hFA, 1'b0, 1'b0, 26);

        // Saturation and extreme operands
        run_op("max_div1",   24'h7FFFFF, 8'h01, 16'h7FFF, 8'h00, 1'b1, 1'b0, 26);
        run_op("min_divm1",  24'h800000, 8'hFF, 16'h7FFF, 8'h00, 1'b1, 1'b0, 26);
        run_op("min_div127", 24'h800000, 8'h7F, 16'h8000, 8'hFC, 1'b1, 1'b0, 26);

        // Divide by zero
        run_op("pos_dz", 24'h000005, 8'h00, 16'h7FFF, 8'h05, 1'b0, 1'b1, 2);
        run_op("neg_dz", 24'hFFFFFB, 8'h00, 16'h8000, 8'hFB, 1'b0, 1'b1, 2);

        // Backpressure: 12345 / -10 = -1234 r 5
        start_op(24'h003039, 8'hF6);
        wait_vld(n);
        check("bp_lat", 32'(n), 32'(26));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_vld_hold", 32'(dif.dout_vld), 32'(1));
            check("bp_rdy_low",  32'(dif.din_rdy),  32'(0));
            check("bp_q_hold",   32'(dif.quotient), 32'(16'hFB2E));
        end
        check_result("bp", 16'hFB2E, 8'h05, 1'b0, 1'b0);
        consume("bp");

        // ce stall mid-CALC: 50000 / 99 = 505 r 5
        start_op(24'h00C350, 8'h63);
        n = 0;
        repeat (5) begin tick(); n++; end
        ce = 1'b0;
        repeat (5) begin tick(); n++; end
        check("ce_state_frozen", 32'(dbg_state),    32'(CALC));
        check("ce_vld_low",      32'(dif.dout_vld), 32'(0));
        ce = 1'b1;
        while (n < 200 && dif.dout_vld !== 1'b1) begin tick(); n++; end
        check("ce_lat", 32'(n), 32'(31));
        check_result("ce", 16'h01F9, 8'h05, 1'b0, 1'b0);
        consume("ce");

        // Asynchronous reset mid-CALC discards the operation
        start_op(24'h0003E8, 8'h07);
        repeat (5) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state",    32'(dbg_state),     32'(IDLE));
        check("arst_din_rdy",  32'(dif.din_rdy),   32'(1));
        check("arst_dout_vld", 32'(dif.dout_vld),  32'(0));
        check("arst_q",        32'(dif.quotient),  32'(0));
        check("arst_r",        32'(dif.remainder), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run_op("post_rst", 24'h000064, 8'h80, 16'h0000, 8'h64, 1'b0, 1'b0, 26);

        // Random sweep with ce gaps and delayed consumption
        for (int i = 0; i < 24; i++) begin
            x16  = 16'($urandom_range(0, 65535));
            rdvd = (i % 3 == 0) ? 24'($urandom_range(0, 24'hFFFFFF)) : {{8{x16[15]}}, x16};
            rdsr = (i % 8 == 5) ? 8'h00 : 8'($urandom_range(0, 255));
            model(rdvd, rdsr, mq, mr, movf, mdz);
            ce = 1'b1;
            start_op(rdvd, rdsr);
            n = 0;
            while (n < 400 && dif.dout_vld !== 1'b1) begin
                ce = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            ce = 1'b1;
            check("sweep_vld", 32'(dif.dout_vld), 32'(1));
            repeat ($urandom_range(0, 3)) tick();
            check_result("sweep", mq, mr, movf, mdz);
            consume("sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
